// File: rtl/if_id_queue_if.sv
// Fetch-side and decode-side handshake bundle for the IF/ID queue.
// The queue is attached through the slave modport; whoever drives fetch and ID uses master.
interface if_id_queue_if #(
    parameter int XLEN  = 32,
    parameter int ILEN  = 32,
    parameter int DEPTH = 2
);
    logic                           if_valid;
    logic [XLEN-1:0]                if_pc;
    logic [ILEN-1:0]                if_instr;
    logic                           if_ready;
    logic                           redirect;
    logic                           id_valid;
    logic [XLEN-1:0]                id_pc;
    logic [ILEN-1:0]                id_instr;
    logic                           id_ready;
    logic [$clog2(DEPTH+1)-1:0]     occupancy;
    logic                           squashing;

    modport master (
        output if_valid, if_pc, if_instr, redirect, id_ready,
        input  if_ready, id_valid, id_pc, id_instr, occupancy, squashing
    );

    modport slave (
        input  if_valid, if_pc, if_instr, redirect, id_ready,
        output if_ready, id_valid, id_pc, id_instr, occupancy, squashing
    );
endinterface

// File: rtl/if_id_queue.sv
// Fetch-to-decode FIFO stage with branch squash of queued and in-flight wrong-path beats.
// Shows a NOP bubble to decode whenever the queue is empty.
module if_id_queue #(
    parameter int              XLEN     = 32,
    parameter int              ILEN     = 32,
    parameter int              DEPTH    = 2,
    parameter int              SQUASH_N = 1,
    parameter logic [ILEN-1:0] NOP      = ILEN'(32'h0000_0013)
) (
    input  logic          clk,
    input  logic          rst,
    if_id_queue_if.slave  bus
);
    localparam int OCC_W = $clog2(DEPTH + 1);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int SQ_W  = (SQUASH_N > 0) ? $clog2(SQUASH_N + 1) : 1;

    logic [XLEN-1:0]  mem_pc    [DEPTH];
    logic [ILEN-1:0]  mem_instr [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [OCC_W-1:0] count;
    logic [SQ_W-1:0]  squash_cnt;

    logic squash_active;
    logic full;
    logic push;
    logic pop;

    // Pointers wrap explicitly so DEPTH need not be a power of two.
    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign squash_active = (squash_cnt != '0);
    assign full          = (count == OCC_W'(DEPTH));
    assign bus.if_ready  = !full || squash_active;
    assign push          = bus.if_valid && bus.if_ready && !bus.redirect && !squash_active;
    assign pop           = (count != '0) && bus.id_ready && !bus.redirect;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count      <= '0;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            squash_cnt <= '0;
        end else if (bus.redirect) begin
            count      <= '0;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            squash_cnt <= SQ_W'(SQUASH_N);
        end else begin
            if (push) begin
                wr_ptr <= next_ptr(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (!push && pop) begin
                count <= count - 1'b1;
            end
            // Wrong-path beats are swallowed regardless of decode stalls.
            if (squash_active && bus.if_valid) begin
                squash_cnt <= squash_cnt - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_pc[wr_ptr]    <= bus.if_pc;
            mem_instr[wr_ptr] <= bus.if_instr;
        end
    end

    assign bus.id_valid  = (count != '0);
    assign bus.id_pc     = bus.id_valid ? mem_pc[rd_ptr] : '0;
    assign bus.id_instr  = bus.id_valid ? mem_instr[rd_ptr] : NOP;
    assign bus.occupancy = count;
    assign bus.squashing = squash_active;
endmodule
